// File: rtl/hex_rot_pkg.sv
// Shared constants for the rotating hex-word monitor:
// segment patterns, invalid marker and FSM encoding.
package hex_rot_pkg;

    localparam logic [6:0] SEG_SYM0 = 7'b0101000;
    localparam logic [6:0] SEG_SYM1 = 7'b1000001;
    localparam logic [6:0] SEG_SYM2 = 7'b1110001;
    localparam logic [6:0] SEG_SYM3 = 7'b0110000;

    typedef struct packed {
        logic       valid;
        logic [1:0] sym;
    } sym_t;

    localparam sym_t SYM_INVALID = '{valid: 1'b0, sym: 2'd0};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_ERROR  = 2'd2
    } state_t;

endpackage

// File: rtl/seg_to_sym.sv
// Combinational decode of one active-low 7-segment
// pattern into a 2-bit rotation symbol.
module seg_to_sym
    import hex_rot_pkg::*;
(
    input  logic [0:6] seg,
    output logic [1:0] sym,
    output logic       valid
);

    sym_t dec;

    always_comb begin
        dec = SYM_INVALID;
        unique case (1'b1)
            (seg == SEG_SYM0): dec = '{valid: 1'b1, sym: 2'd0};
            (seg == SEG_SYM1): dec = '{valid: 1'b1, sym: 2'd1};
            (seg == SEG_SYM2): dec = '{valid: 1'b1, sym: 2'd2};
            (seg == SEG_SYM3): dec = '{valid: 1'b1, sym: 2'd3};
            default:           dec = SYM_INVALID;
        endcase
    end

    assign sym   = dec.sym;
    assign valid = dec.valid;

endmodule

// File: rtl/hex_rotation_monitor.sv
// Tracks a four-digit rotating symbol word, counting
// single-position steps and malformed frames.
module hex_rotation_monitor
    import hex_rot_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             aclr,
    input  logic [0:6]       hex3,
    input  logic [0:6]       hex2,
    input  logic [0:6]       hex1,
    input  logic [0:6]       hex0,
    input  logic             sample,
    output logic             locked,
    output logic             err,
    output logic [1:0]       offset,
    output logic             dir,
    output logic [CNT_W-1:0] step_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    logic [1:0] sym3, sym2, sym1, sym0;
    logic       vld3, vld2, vld1, vld0;

    seg_to_sym u_sym3 (.seg(hex3), .sym(sym3), .valid(vld3));
    seg_to_sym u_sym2 (.seg(hex2), .sym(sym2), .valid(vld2));
    seg_to_sym u_sym1 (.seg(hex1), .sym(sym1), .valid(vld1));
    seg_to_sym u_sym0 (.seg(hex0), .sym(sym0), .valid(vld0));

    logic frame_valid;
    logic [1:0] delta;

    // Sums are 2 bits wide, so the comparisons wrap mod 4.
    always_comb begin
        frame_valid = vld3 & vld2 & vld1 & vld0
                    & (sym2 == 2'(sym3 + 2'd1))
                    & (sym1 == 2'(sym3 + 2'd2))
                    & (sym0 == 2'(sym3 + 2'd3));
        delta = 2'(sym3 - offset);
    end

    state_t           state_q, state_d;
    logic [1:0]       offset_d;
    logic             dir_d;
    logic [CNT_W-1:0] step_d, err_d;
    logic [CNT_W-1:0] err_inc;

    assign err_inc = (&err_cnt) ? err_cnt : err_cnt + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        offset_d = offset;
        dir_d    = dir;
        step_d   = step_cnt;
        err_d    = err_cnt;
        if (sample) begin
            if (!frame_valid) begin
                state_d = ST_ERROR;
                err_d   = err_inc;
            end else begin
                offset_d = sym3;
                case (state_q)
                    ST_LOCKED: begin
                        case (delta)
                            2'd1: begin
                                dir_d  = 1'b1;
                                step_d = step_cnt + CNT_W'(1);
                            end
                            2'd3: begin
                                dir_d  = 1'b0;
                                step_d = step_cnt + CNT_W'(1);
                            end
                            2'd2: begin
                                state_d = ST_ERROR;
                                err_d   = err_inc;
                            end
                            default: ;
                        endcase
                    end
                    default: state_d = ST_LOCKED;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q  <= ST_IDLE;
            locked   <= 1'b0;
            err      <= 1'b0;
            offset   <= 2'd0;
            dir      <= 1'b0;
            step_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            locked   <= (state_d == ST_LOCKED);
            err      <= (state_d == ST_ERROR);
            offset   <= offset_d;
            dir      <= dir_d;
            step_cnt <= step_d;
            err_cnt  <= err_d;
        end
    end

endmodule

// File: tb/tb_hex_rotation_monitor.sv
// Directed and random frames against a table-driven
// reference of the rotating-word monitor.
module tb_hex_rotation_monitor;

    logic       clk = 1'b0;
    logic       aclr = 1'b0;
    logic [0:6] hex3, hex2, hex1, hex0;
    logic       sample;
    logic       locked, err, dir;
    logic [1:0] offset;
    logic [7:0] step_cnt, err_cnt;

    hex_rotation_monitor #(.CNT_W(8)) dut (
        .clk(clk), .aclr(aclr),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .sample(sample),
        .locked(locked), .err(err), .offset(offset), .dir(dir),
        .step_cnt(step_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [0:6] pat [4];
    int total = 0;
    int bad = 0;

    // Reference: mode 0 idle, 1 tracking, 2 error
    int m_mode, m_off, m_dir, m_step, m_err;

    function automatic int dec(logic [0:6] p);
        for (int i = 0; i < 4; i++)
            if (p === pat[i]) return i;
        return -1;
    endfunction

    task automatic m_reset();
        m_mode = 0; m_off = 0; m_dir = 0; m_step = 0; m_err = 0;
    endtask

    task automatic m_bad();
        m_mode = 2;
        if (m_err < 255) m_err++;
    endtask

    task automatic m_edge();
        int d3, d2, d1, d0, dl;
        bit ok;
        if (!sample) return;
        d3 = dec(hex3); d2 = dec(hex2); d1 = dec(hex1); d0 = dec(hex0);
        ok = d3 >= 0 && d2 >= 0 && d1 >= 0 && d0 >= 0
          && d2 == (d3 + 1) % 4 && d1 == (d3 + 2) % 4
          && d0 == (d3 + 3) % 4;
        if (!ok) begin
            m_bad();
        end else if (m_mode != 1) begin
            m_off = d3; m_mode = 1;
        end else begin
            dl = (d3 - m_off + 4) % 4;
            if (dl == 1) begin m_dir = 1; m_step = (m_step + 1) % 256; end
            if (dl == 3) begin m_dir = 0; m_step = (m_step + 1) % 256; end
            if (dl == 2) m_bad();
            m_off = d3;
        end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(string tag);
        check({tag, ".locked"}, 32'(locked), 32'(m_mode == 1));
        check({tag, ".err"}, 32'(err), 32'(m_mode == 2));
        check({tag, ".offset"}, 32'(offset), 32'(m_off));
        check({tag, ".dir"}, 32'(dir), 32'(m_dir));
        check({tag, ".step"}, 32'(step_cnt), 32'(m_step));
        check({tag, ".errcnt"}, 32'(err_cnt), 32'(m_err));
    endtask

    task automatic put(int off, bit s);
        hex3 = pat[off % 4];
        hex2 = pat[(off + 1) % 4];
        hex1 = pat[(off + 2) % 4];
        hex0 = pat[(off + 3) % 4];
        sample = s;
    endtask

    task automatic cyc(string tag);
        @(posedge clk);
        m_edge();
        #1;
        check_all(tag);
    endtask

    task automatic frame(int off, string tag);
        put(off, 1'b1);
        cyc(tag);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 aclr = 1'b1;
        m_reset();
        #1 check_all("reset");
        @(posedge clk);
        #1 aclr = 1'b0;
    endtask

    initial begin
        pat[0] = 7'b0101000;
        pat[1] = 7'b1000001;
        pat[2] = 7'b1110001;
        pat[3] = 7'b0110000;
        put(0, 1'b0);
        m_reset();
        #2 aclr = 1'b1;
        #1 check_all("por");
        @(posedge clk);
        #1 aclr = 1'b0;

        // Lock then four up-steps
        frame(0, "up0"); frame(1, "up1"); frame(2, "up2");
        frame(3, "up3"); frame(0, "up4");
        check("up.step4", 32'(step_cnt), 32'd4);
        check("up.off0", 32'(offset), 32'd0);

        frame(3, "dn3"); frame(2, "dn2");
        check("dn.step6", 32'(step_cnt), 32'd6);
        check("dn.dir0", 32'(dir), 32'd0);

        frame(1, "to1"); frame(3, "skip");
        check("skip.err", 32'(err), 32'd1);
        frame(0, "relock");

        put(1, 1'b1);
        hex1 = 7'b1111111;
        cyc("blank");
        check("blank.off", 32'(offset), 32'd0);
        for (int i = 0; i < 299; i++) begin
            put(i % 4, 1'b1);
            hex0 = 7'(i);
            if (i % 4 == 2) hex0 = 7'h7f;
            @(posedge clk); m_edge();
        end
        #1 check_all("sat");
        check("sat.255", 32'(err_cnt), 32'd255);

        frame(2, "hold.lock");
        for (int i = 0; i < 10; i++) begin
            put(i, 1'b0);
            cyc("hold");
        end
        put(3, 1'b1);
        @(posedge clk);
        m_edge();
        #2 aclr = 1'b1;
        m_reset();
        #1 check_all("midrst");
        #1 aclr = 1'b0;
        frame(1, "post");
        check("post.lock", 32'(locked), 32'd1);

        do_reset();
        frame(0, "wrap.lock");
        for (int i = 1; i <= 256; i++) frame(i, "wrap");
        check("wrap.zero", 32'(step_cnt), 32'd0);

        do_reset();
        for (int i = 0; i < 400; i++) begin
            put($urandom_range(3), 1'($urandom_range(3) != 0));
            if ($urandom_range(7) == 0) hex2 = 7'($urandom);
            if ($urandom_range(15) == 0) hex3 = pat[$urandom_range(3)];
            cyc("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
